// File: rtl/tlk2711_pkg.sv
// Shared TLK2711 link definitions: K-word encodings, receive FSM states and word classes.
// Imported by both the TX generator and the RX checker.
package tlk2711_pkg;

  localparam logic [15:0] KWordIdle  = 16'hBC50;
  localparam logic [15:0] KWordSof   = 16'hFBFB;
  localparam logic [15:0] KWordEof   = 16'hFDFD;
  // K-flag pairs ordered {msb, lsb}
  localparam logic [1:0]  KFlagsIdle = 2'b10;
  localparam logic [1:0]  KFlagsCtrl = 2'b11;
  localparam logic [1:0]  KFlagsData = 2'b00;

  typedef enum logic [1:0] {
    StUnsync,
    StIdle,
    StFrame
  } rx_state_e;

  typedef enum logic [2:0] {
    WcIdle,
    WcSof,
    WcEof,
    WcData,
    WcBad
  } word_class_e;

  function automatic word_class_e classify_word(input logic [15:0] word,
                                                input logic [1:0]  kflags);
    word_class_e wc;
    if (kflags == KFlagsData) begin
      wc = WcData;
    end else if (kflags == KFlagsIdle && word == KWordIdle) begin
      wc = WcIdle;
    end else if (kflags == KFlagsCtrl && word == KWordSof) begin
      wc = WcSof;
    end else if (kflags == KFlagsCtrl && word == KWordEof) begin
      wc = WcEof;
    end else begin
      wc = WcBad;
    end
    return wc;
  endfunction

endpackage

// File: rtl/tlk2711_word_class.sv
// Input register stage for the TLK2711 receive word; classifies the registered word
// so that all decode logic downstream sees a stable, registered view of the link.
module tlk2711_word_class
  import tlk2711_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] rxd_i,
  input  logic        rkmsb_i,
  input  logic        rklsb_i,
  input  logic        clr_cnt_i,
  output word_class_e wclass_o,
  output logic [15:0] data_o,
  output logic        clr_cnt_o
);

  logic [15:0] rxd_q;
  logic [1:0]  k_q;
  logic        clr_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rxd_q <= '0;
      k_q   <= '0;
      clr_q <= 1'b0;
    end else begin
      rxd_q <= rxd_i;
      k_q   <= {rkmsb_i, rklsb_i};
      clr_q <= clr_cnt_i;
    end
  end

  assign wclass_o  = classify_word(rxd_q, k_q);
  assign data_o    = rxd_q;
  assign clr_cnt_o = clr_q;

endmodule

// File: rtl/tlk2711_rx_checker.sv
// TLK2711 receive checker: word sync from K28.5 idles, SOF/EOF framing, incrementing
// payload check, payload stream output and saturating good/bad frame counters.
module tlk2711_rx_checker
  import tlk2711_pkg::*;
#(
  parameter int unsigned SYNC_CNT = 16,
  parameter int unsigned LOSS_CNT = 4,
  parameter int unsigned MAX_LEN  = 4096,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      i_rxd,
  input  logic             i_rkmsb,
  input  logic             i_rklsb,
  input  logic             i_clr_cnt,
  output logic             o_link_up,
  output logic [15:0]      o_data,
  output logic             o_valid,
  output logic             o_sof,
  output logic             o_eof,
  output logic             o_frame_err,
  output logic [15:0]      o_len,
  output logic [CNT_W-1:0] o_frame_cnt,
  output logic [CNT_W-1:0] o_err_cnt
);

  localparam int unsigned SyncW = $clog2(SYNC_CNT + 1);
  localparam int unsigned LossW = $clog2(LOSS_CNT + 1);

  word_class_e wclass;
  logic [15:0] wdata;
  logic        clr;

  tlk2711_word_class u_word_class (
    .clk_i     (clk),
    .rst_i     (rst),
    .rxd_i     (i_rxd),
    .rkmsb_i   (i_rkmsb),
    .rklsb_i   (i_rklsb),
    .clr_cnt_i (i_clr_cnt),
    .wclass_o  (wclass),
    .data_o    (wdata),
    .clr_cnt_o (clr)
  );

  rx_state_e        st_q, st_d;
  logic [SyncW-1:0] sync_cnt_q, sync_cnt_d;
  logic [LossW-1:0] loss_cnt_q, loss_cnt_d;
  logic [15:0]      len_q, len_d;
  logic [15:0]      prev_q, prev_d;
  logic             mism_q, mism_d;
  logic [15:0]      buf_q, buf_d;
  logic             buf_vld_q, buf_vld_d;
  logic             buf_sof_q, buf_sof_d;
  logic [15:0]      data_q, data_d;
  logic             valid_q, valid_d;
  logic             sof_q, sof_d;
  logic             eof_q, eof_d;
  logic             ferr_q, ferr_d;
  logic [15:0]      olen_q, olen_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic frame_inc, err_inc, abort, close, loss_inc;

  always_comb begin
    st_d        = st_q;
    sync_cnt_d  = sync_cnt_q;
    loss_cnt_d  = loss_cnt_q;
    len_d       = len_q;
    prev_d      = prev_q;
    mism_d      = mism_q;
    buf_d       = buf_q;
    buf_vld_d   = buf_vld_q;
    buf_sof_d   = buf_sof_q;
    data_d      = data_q;
    olen_d      = olen_q;
    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;
    valid_d     = 1'b0;
    sof_d       = 1'b0;
    eof_d       = 1'b0;
    ferr_d      = 1'b0;
    frame_inc   = 1'b0;
    err_inc     = 1'b0;
    abort       = 1'b0;
    close       = 1'b0;
    loss_inc    = 1'b0;

    unique case (st_q)
      StUnsync: begin
        if (wclass == WcIdle) begin
          if (sync_cnt_q == SyncW'(SYNC_CNT - 1)) begin
            st_d       = StIdle;
            sync_cnt_d = '0;
            loss_cnt_d = '0;
          end else begin
            sync_cnt_d = sync_cnt_q + 1'b1;
          end
        end else begin
          sync_cnt_d = '0;
        end
      end
      StIdle: begin
        unique case (wclass)
          WcSof: begin
            st_d       = StFrame;
            loss_cnt_d = '0;
            len_d      = '0;
            mism_d     = 1'b0;
            buf_vld_d  = 1'b0;
          end
          WcIdle, WcEof: loss_cnt_d = '0;
          WcBad:         loss_inc = 1'b1;
          default: ;
        endcase
      end
      StFrame: begin
        unique case (wclass)
          WcData: begin
            if (len_q == 16'(MAX_LEN)) begin
              abort = 1'b1;
            end else begin
              // The previous word becomes visible only now that we know it is not the last.
              valid_d   = buf_vld_q;
              sof_d     = buf_vld_q & buf_sof_q;
              if (buf_vld_q) data_d = buf_q;
              buf_d     = wdata;
              buf_vld_d = 1'b1;
              buf_sof_d = (len_q == '0);
              if (len_q != '0 && wdata != prev_q + 16'd1) mism_d = 1'b1;
              prev_d    = wdata;
              len_d     = len_q + 16'd1;
            end
          end
          WcEof: begin
            loss_cnt_d = '0;
            close      = 1'b1;
            if (len_q != '0 && !mism_q) begin
              frame_inc = 1'b1;
              olen_d    = len_q;
            end else begin
              ferr_d  = 1'b1;
              err_inc = 1'b1;
            end
          end
          WcSof, WcIdle: begin
            loss_cnt_d = '0;
            abort      = 1'b1;
          end
          WcBad: begin
            loss_inc = 1'b1;
            abort    = 1'b1;
          end
          default: ;
        endcase
      end
      default: st_d = StUnsync;
    endcase

    if (close || abort) begin
      valid_d   = buf_vld_q;
      sof_d     = buf_vld_q & buf_sof_q;
      eof_d     = buf_vld_q;
      if (buf_vld_q) data_d = buf_q;
      buf_vld_d = 1'b0;
      st_d      = StIdle;
    end
    if (abort) begin
      ferr_d  = 1'b1;
      err_inc = 1'b1;
    end

    // err_inc is a flag, so an abort coinciding with link loss still counts once.
    if (loss_inc) begin
      if (loss_cnt_q == LossW'(LOSS_CNT - 1)) begin
        st_d       = StUnsync;
        loss_cnt_d = '0;
        sync_cnt_d = '0;
        err_inc    = 1'b1;
      end else begin
        loss_cnt_d = loss_cnt_q + 1'b1;
      end
    end

    if (clr) begin
      frame_cnt_d = '0;
      err_cnt_d   = '0;
    end else begin
      if (frame_inc && frame_cnt_q != '1) frame_cnt_d = frame_cnt_q + CNT_W'(1);
      if (err_inc && err_cnt_q != '1)     err_cnt_d   = err_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q        <= StUnsync;
      sync_cnt_q  <= '0;
      loss_cnt_q  <= '0;
      len_q       <= '0;
      prev_q      <= '0;
      mism_q      <= 1'b0;
      buf_q       <= '0;
      buf_vld_q   <= 1'b0;
      buf_sof_q   <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      sof_q       <= 1'b0;
      eof_q       <= 1'b0;
      ferr_q      <= 1'b0;
      olen_q      <= '0;
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      st_q        <= st_d;
      sync_cnt_q  <= sync_cnt_d;
      loss_cnt_q  <= loss_cnt_d;
      len_q       <= len_d;
      prev_q      <= prev_d;
      mism_q      <= mism_d;
      buf_q       <= buf_d;
      buf_vld_q   <= buf_vld_d;
      buf_sof_q   <= buf_sof_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      sof_q       <= sof_d;
      eof_q       <= eof_d;
      ferr_q      <= ferr_d;
      olen_q      <= olen_d;
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign o_link_up   = (st_q != StUnsync);
  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_sof       = sof_q;
  assign o_eof       = eof_q;
  assign o_frame_err = ferr_q;
  assign o_len       = olen_q;
  assign o_frame_cnt = frame_cnt_q;
  assign o_err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_tlk2711_rx_checker.sv
// Directed bench for tlk2711_rx_checker: sync, framing, pattern check, aborts,
// link loss, counter clear/saturation and mid-frame reset.
module tb_tlk2711_rx_checker;
  import tlk2711_pkg::*;

  localparam int unsigned CntW = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [15:0]     rxd;
  logic            rkmsb, rklsb, clr_cnt;
  logic            link_up, valid, sof, eof, frame_err;
  logic [15:0]     data, len;
  logic [CntW-1:0] frame_cnt, err_cnt;

  tlk2711_rx_checker #(
    .SYNC_CNT (16),
    .LOSS_CNT (4),
    .MAX_LEN  (8),
    .CNT_W    (CntW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_rxd       (rxd),
    .i_rkmsb     (rkmsb),
    .i_rklsb     (rklsb),
    .i_clr_cnt   (clr_cnt),
    .o_link_up   (link_up),
    .o_data      (data),
    .o_valid     (valid),
    .o_sof       (sof),
    .o_eof       (eof),
    .o_frame_err (frame_err),
    .o_len       (len),
    .o_frame_cnt (frame_cnt),
    .o_err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          ferr_seen = 0;
  int          t0;
  logic [17:0] beats[$];
  int          beat_cyc[$];

  // Outputs only change on posedge, so sampling on negedge is race-free.
  always @(negedge clk) begin
    cyc++;
    if (valid) begin
      beats.push_back({sof, eof, data});
      beat_cyc.push_back(cyc);
    end
    if (frame_err) ferr_seen++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_beat(input string tag, input int idx, input logic s, input logic e,
                          input logic [15:0] d);
    logic [17:0] obs;
    obs = (idx < beats.size()) ? beats[idx] : 18'bx;
    chk(tag, 32'(obs), 32'({s, e, d}));
  endtask

  task automatic send(input logic [15:0] d, input logic [1:0] k, input logic clr = 1'b0);
    @(negedge clk);
    #1;
    rxd            = d;
    {rkmsb, rklsb} = k;
    clr_cnt        = clr;
  endtask

  task automatic idles(input int n);
    for (int i = 0; i < n; i++) send(KWordIdle, KFlagsIdle);
  endtask

  task automatic w_sof();
    send(KWordSof, KFlagsCtrl);
  endtask

  task automatic w_eof(input logic clr = 1'b0);
    send(KWordEof, KFlagsCtrl, clr);
  endtask

  task automatic w_dat(input logic [15:0] d);
    send(d, KFlagsData);
  endtask

  task automatic w_bad();
    send(16'h0000, 2'b01);
  endtask

  task automatic clear_mon();
    beats.delete();
    beat_cyc.delete();
    ferr_seen = 0;
  endtask

  initial begin
    rst = 1'b1; rxd = '0; rkmsb = 1'b0; rklsb = 1'b0; clr_cnt = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_flags", 32'({link_up, valid, sof, eof, frame_err}), 32'd0);
    chk("reset_data_len", 32'({data, len}), 32'd0);
    chk("reset_counters", 32'({frame_cnt, err_cnt}), 32'd0);
    #1 rst = 1'b0;

    // Sync: 15 idles is one short
    idles(15);
    for (int i = 0; i < 3; i++) w_dat(16'h0000);
    chk("sync_15_idles", 32'(link_up), 32'd0);
    idles(16);
    @(negedge clk);
    chk("sync_16_pending", 32'(link_up), 32'd0);
    @(negedge clk);
    chk("sync_16_up", 32'(link_up), 32'd1);

    // Good frame with latency check
    clear_mon();
    w_sof();
    w_dat(16'h0010); t0 = cyc;
    w_dat(16'h0011); w_dat(16'h0012); w_dat(16'h0013);
    w_eof();
    idles(4);
    chk("good_nbeats", 32'(beats.size()), 32'd4);
    chk_beat("good_b0", 0, 1'b1, 1'b0, 16'h0010);
    chk_beat("good_b1", 1, 1'b0, 1'b0, 16'h0011);
    chk_beat("good_b2", 2, 1'b0, 1'b0, 16'h0012);
    chk_beat("good_b3", 3, 1'b0, 1'b1, 16'h0013);
    chk("good_latency", 32'((beat_cyc.size() > 0) ? beat_cyc[0] - t0 : -1), 32'd3);
    chk("good_len", 32'(len), 32'd4);
    chk("good_fcnt", 32'(frame_cnt), 32'd1);
    chk("good_ferr", 32'(ferr_seen), 32'd0);
    chk("good_ecnt", 32'(err_cnt), 32'd0);

    // Wrap 0xFFFF -> 0x0000 is legal
    clear_mon();
    w_sof(); w_dat(16'hFFFE); w_dat(16'hFFFF); w_dat(16'h0000); w_eof();
    idles(4);
    chk("wrap_nbeats", 32'(beats.size()), 32'd3);
    chk_beat("wrap_b2", 2, 1'b0, 1'b1, 16'h0000);
    chk("wrap_len", 32'(len), 32'd3);
    chk("wrap_fcnt", 32'(frame_cnt), 32'd2);
    chk("wrap_ferr", 32'(ferr_seen), 32'd0);

    // Pattern mismatch streams fully, flagged at EOF
    clear_mon();
    w_sof(); w_dat(16'h0005); w_dat(16'h0007); w_eof();
    idles(4);
    chk("mism_nbeats", 32'(beats.size()), 32'd2);
    chk_beat("mism_b1", 1, 1'b0, 1'b1, 16'h0007);
    chk("mism_ferr", 32'(ferr_seen), 32'd1);
    chk("mism_ecnt", 32'(err_cnt), 32'd1);
    chk("mism_fcnt", 32'(frame_cnt), 32'd2);
    chk("mism_len", 32'(len), 32'd3);

    // SOF inside frame aborts; following data/EOF are outside any frame
    clear_mon();
    w_sof(); w_dat(16'h0001); w_sof(); w_dat(16'h0002); w_eof();
    idles(4);
    chk("sofab_nbeats", 32'(beats.size()), 32'd1);
    chk_beat("sofab_b0", 0, 1'b1, 1'b1, 16'h0001);
    chk("sofab_ferr", 32'(ferr_seen), 32'd1);
    chk("sofab_ecnt", 32'(err_cnt), 32'd2);
    chk("sofab_fcnt", 32'(frame_cnt), 32'd2);

    // Nine words with MAX_LEN=8 aborts after the ninth
    clear_mon();
    w_sof();
    for (int i = 1; i <= 9; i++) w_dat(16'(i));
    idles(4);
    chk("maxab_nbeats", 32'(beats.size()), 32'd8);
    chk_beat("maxab_b0", 0, 1'b1, 1'b0, 16'h0001);
    chk_beat("maxab_b7", 7, 1'b0, 1'b1, 16'h0008);
    chk("maxab_ferr", 32'(ferr_seen), 32'd1);
    chk("maxab_ecnt", 32'(err_cnt), 32'd3);

    // Exactly MAX_LEN words is a good frame
    clear_mon();
    w_sof();
    for (int i = 1; i <= 8; i++) w_dat(16'(i));
    w_eof();
    idles(4);
    chk("max_nbeats", 32'(beats.size()), 32'd8);
    chk("max_len", 32'(len), 32'd8);
    chk("max_fcnt", 32'(frame_cnt), 32'd3);
    chk("max_ferr", 32'(ferr_seen), 32'd0);

    // Single-word frame
    clear_mon();
    w_sof(); w_dat(16'h0042); w_eof();
    idles(4);
    chk("single_nbeats", 32'(beats.size()), 32'd1);
    chk_beat("single_b0", 0, 1'b1, 1'b1, 16'h0042);
    chk("single_len", 32'(len), 32'd1);
    chk("single_fcnt", 32'(frame_cnt), 32'd4);

    // Empty frame is bad
    clear_mon();
    w_sof(); w_eof();
    idles(4);
    chk("empty_nbeats", 32'(beats.size()), 32'd0);
    chk("empty_ferr", 32'(ferr_seen), 32'd1);
    chk("empty_ecnt", 32'(err_cnt), 32'd4);
    chk("empty_len", 32'(len), 32'd1);

    // Idle between bad bursts resets the loss count
    for (int i = 0; i < 3; i++) w_bad();
    idles(1);
    for (int i = 0; i < 3; i++) w_bad();
    idles(4);
    chk("loss_hold_link", 32'(link_up), 32'd1);
    chk("loss_hold_ecnt", 32'(err_cnt), 32'd4);

    // Four bad words drop the link
    for (int i = 0; i < 4; i++) w_bad();
    w_dat(16'h0000); w_dat(16'h0000);
    chk("loss_link", 32'(link_up), 32'd0);
    chk("loss_ecnt", 32'(err_cnt), 32'd5);
    idles(18);
    chk("resync_link", 32'(link_up), 32'd1);

    // Error counter saturates at 7
    for (int i = 0; i < 2; i++) begin
      w_sof(); w_eof();
    end
    idles(4);
    chk("esat_7", 32'(err_cnt), 32'd7);
    w_sof(); w_eof();
    idles(4);
    chk("esat_hold", 32'(err_cnt), 32'd7);

    // Clear coincident with a good EOF wins
    w_sof(); w_dat(16'h0020); w_eof(1'b1);
    idles(4);
    chk("clr_fcnt", 32'(frame_cnt), 32'd0);
    chk("clr_ecnt", 32'(err_cnt), 32'd0);
    chk("clr_len", 32'(len), 32'd1);

    // Frame counter saturates at 7
    for (int i = 0; i < 7; i++) begin
      w_sof(); w_dat(16'h0030); w_dat(16'h0031); w_eof();
    end
    idles(4);
    chk("fsat_7", 32'(frame_cnt), 32'd7);
    chk("fsat_len", 32'(len), 32'd2);
    w_sof(); w_dat(16'h0030); w_eof();
    idles(4);
    chk("fsat_hold", 32'(frame_cnt), 32'd7);

    // Reset mid-frame: no trailing beat or error pulse
    w_sof(); w_dat(16'h0001); w_dat(16'h0002); w_dat(16'h0003);
    @(negedge clk);
    #1;
    clear_mon();
    rst = 1'b1;
    rxd = KWordIdle; {rkmsb, rklsb} = KFlagsIdle;
    repeat (2) @(negedge clk);
    chk("rstmid_flags", 32'({link_up, valid, sof, eof, frame_err}), 32'd0);
    chk("rstmid_len", 32'(len), 32'd0);
    chk("rstmid_counters", 32'({frame_cnt, err_cnt}), 32'd0);
    #1 rst = 1'b0;
    idles(6);
    chk("rstmid_nbeats", 32'(beats.size()), 32'd0);
    chk("rstmid_ferr", 32'(ferr_seen), 32'd0);
    chk("rstmid_link", 32'(link_up), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
